// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer for the unified instruction/data memory.
// Grants one requester (core or DMA) at a time and runs IDLE -> ISSUE -> WAIT -> DONE.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_done,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       last_dma;
  logic       pick_dma;

  // On a tie the port that was not served last wins; a lone requester always wins.
  assign pick_dma  = dma_req & (~cpu_req | ~last_dma);
  assign cpu_stall = cpu_req & ~cpu_done;

  // NOTE: every register here, including rdata, is cleared by the asynchronous
  // reset so an abandoned access leaves no grant, strobe or done pulse behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last_dma  <= 1'b1;
      gnt       <= '0;
      cpu_done  <= 1'b0;
      dma_done  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge values of state, gnt and mem_we.
      case (state)
        IDLE: begin
          if (cpu_req || dma_req) begin
            gnt       <= pick_dma ? 2'b10 : 2'b01;
            mem_en    <= 1'b1;
            mem_we    <= pick_dma ? dma_we    : cpu_we;
            mem_addr  <= pick_dma ? dma_addr  : cpu_addr;
            mem_wdata <= pick_dma ? dma_wdata : cpu_wdata;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          // mem_we still holds the latched direction during the issue cycle.
          if (mem_we) begin
            cpu_done <= gnt[0];
            dma_done <= gnt[1];
            state    <= DONE;
          end else begin
            cnt   <= LAT_M1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rdata    <= mem_rdata;
            cpu_done <= gnt[0];
            dma_done <= gnt[1];
            state    <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          cpu_done <= 1'b0;
          dma_done <= 1'b0;
          last_dma <= gnt[1];
          gnt      <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: a MEM_LAT=1 instance with a small memory model
// plus a MEM_LAT=4 instance whose read data is driven cycle by cycle.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_done, cpu_stall, dma_done;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  gnt;
  logic        mem_en, mem_we;

  logic        cpu_req4;
  logic [31:0] cpu_addr4, mem_rdata4;
  logic        cpu_done4, cpu_stall4, dma_done4, mem_en4, mem_we4;
  logic [31:0] rdata4, mem_addr4, mem_wdata4;
  logic [1:0]  gnt4;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_done(dma_done), .rdata(rdata), .gnt(gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) dut4 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req4), .cpu_we(1'b0), .cpu_addr(cpu_addr4), .cpu_wdata(32'h0),
    .cpu_done(cpu_done4), .cpu_stall(cpu_stall4),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'h0), .dma_wdata(32'h0),
    .dma_done(dma_done4), .rdata(rdata4), .gnt(gnt4),
    .mem_en(mem_en4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_rdata(mem_rdata4)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        is_dma;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] model_rdata;

  // Memory model for the MEM_LAT=1 instance: writes commit on the strobe,
  // reads return one cycle after the strobe. Unwritten words have fixed contents.
  logic [31:0] mem_model [256];
  logic        written   [256];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'h5A5A_5A5A);
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem_model[mem_addr[7:0]] <= mem_wdata;
        written[mem_addr[7:0]]   <= 1'b1;
      end else begin
        mem_rdata <= (written[mem_addr[7:0]] === 1'b1) ? mem_model[mem_addr[7:0]]
                                                       : init_val(mem_addr);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    cpu_req4 = 1'b0; cpu_addr4 = '0; mem_rdata4 = '0;
    #2;
    checks++;
    if ({gnt, mem_en, mem_we, mem_addr, mem_wdata, rdata, cpu_done, dma_done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: gnt=%b mem_en=%b mem_we=%b mem_addr=%h mem_wdata=%h rdata=%h done=%b%b, all required 0",
               gnt, mem_en, mem_we, mem_addr, mem_wdata, rdata, dma_done, cpu_done);
    end
    checks++;
    if ({gnt4, mem_en4, rdata4, cpu_done4} !== '0) begin
      failures++;
      $display("FAIL reset_outputs4: gnt=%b mem_en=%b rdata=%h done=%b, all required 0",
               gnt4, mem_en4, rdata4, cpu_done4);
    end
    checks++;
    if (cpu_stall !== 1'b1) begin
      failures++;
      $display("FAIL reset_stall_high: cpu_stall=%b required 1", cpu_stall);
    end
    cpu_req = 1'b0;
    #1;
    checks++;
    if (cpu_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall_low: cpu_stall=%b required 0", cpu_stall);
    end
    @(negedge clk);
    rst = 1'b0;
    model_rdata = '0;
    next_cycle();
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    sb.push_back('{1'b0, 32'hDEADBEEF});
    model_rdata = 32'hDEADBEEF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (cpu_stall !== (c <= 2)) begin
        failures++;
        $display("FAIL cpu_read_stall c=%0d: cpu_stall=%b required %b", c, cpu_stall, (c <= 2));
      end
      checks++;
      if (mem_en !== (c == 1) || cpu_done !== (c == 3)) begin
        failures++;
        $display("FAIL cpu_read_timing c=%0d: mem_en=%b cpu_done=%b required %b %b",
                 c, mem_en, cpu_done, (c == 1), (c == 3));
      end
      if (c == 1) begin
        checks++;
        if ({mem_we, mem_addr, gnt} !== {1'b0, 32'h10, 2'b01}) begin
          failures++;
          $display("FAIL cpu_read_issue: mem_we=%b mem_addr=%h gnt=%b required 0 00000010 01",
                   mem_we, mem_addr, gnt);
        end
      end
      if (cpu_done || dma_done) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_cpu_read: done cpu=%b dma=%b with nothing expected", cpu_done, dma_done);
        end else begin
          e = sb.pop_front();
          if ({dma_done, cpu_done, rdata} !== {e.is_dma, ~e.is_dma, e.data}) begin
            failures++;
            $display("FAIL sb_cpu_read: dma=%b cpu=%b rdata=%h required dma=%b rdata=%h",
                     dma_done, cpu_done, rdata, e.is_dma, e.data);
          end
        end
      end
      next_cycle();
      if (c == 3) cpu_req = 1'b0;
    end
  endtask

  task automatic test_dma_write();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'h1234;
    sb.push_back('{1'b1, model_rdata});
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (mem_en !== (c == 1) || dma_done !== (c == 2) || cpu_done !== 1'b0 || cpu_stall !== 1'b0) begin
        failures++;
        $display("FAIL dma_write_timing c=%0d: mem_en=%b dma_done=%b cpu_done=%b cpu_stall=%b",
                 c, mem_en, dma_done, cpu_done, cpu_stall);
      end
      if (c == 1) begin
        checks++;
        if ({mem_we, mem_addr, mem_wdata, gnt} !== {1'b1, 32'h40, 32'h1234, 2'b10}) begin
          failures++;
          $display("FAIL dma_write_issue: mem_we=%b mem_addr=%h mem_wdata=%h gnt=%b required 1 00000040 00001234 10",
                   mem_we, mem_addr, mem_wdata, gnt);
        end
      end
      if (cpu_done || dma_done) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_dma_write: done cpu=%b dma=%b with nothing expected", cpu_done, dma_done);
        end else begin
          e = sb.pop_front();
          if ({dma_done, cpu_done, rdata} !== {e.is_dma, ~e.is_dma, e.data}) begin
            failures++;
            $display("FAIL sb_dma_write: dma=%b cpu=%b rdata=%h required dma=%b rdata=%h",
                     dma_done, cpu_done, rdata, e.is_dma, e.data);
          end
        end
      end
      next_cycle();
      if (c == 2) dma_req = 1'b0;
    end
  endtask

  task automatic test_tie();
    logic [1:0] gseq [3];
    int  n_iss   = 0;
    int  n_done  = 0;
    bit  overlap = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_rdata = '0;
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h50; cpu_wdata = 32'hA1A1_A1A1;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h40;
    sb.push_back('{1'b0, 32'h0});
    sb.push_back('{1'b1, 32'h1234});
    sb.push_back('{1'b0, 32'h1234});
    model_rdata = 32'h1234;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (gnt === 2'b11) overlap = 1'b1;
      if (mem_en === 1'b1 && n_iss < 3) begin
        gseq[n_iss] = gnt;
        n_iss++;
      end
      if (cpu_done || dma_done) begin
        n_done++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_tie: done cpu=%b dma=%b with nothing expected", cpu_done, dma_done);
        end else begin
          e = sb.pop_front();
          if ({dma_done, cpu_done, rdata} !== {e.is_dma, ~e.is_dma, e.data}) begin
            failures++;
            $display("FAIL sb_tie: dma=%b cpu=%b rdata=%h required dma=%b rdata=%h",
                     dma_done, cpu_done, rdata, e.is_dma, e.data);
          end
        end
      end
      if (n_done == 3) begin
        cpu_req = 1'b0;
        dma_req = 1'b0;
        break;
      end
    end
    checks++;
    if (n_done != 3 || n_iss != 3) begin
      failures++;
      $display("FAIL tie_timeout: issues=%0d dones=%0d required 3 3", n_iss, n_done);
    end else begin
      checks++;
      if ({gseq[0], gseq[1], gseq[2]} !== {2'b01, 2'b10, 2'b01}) begin
        failures++;
        $display("FAIL tie_order: gnt sequence %b %b %b required 01 10 01", gseq[0], gseq[1], gseq[2]);
      end
    end
    checks++;
    if (overlap) begin
      failures++;
      $display("FAIL tie_overlap: gnt=11 observed, required one-hot or zero");
    end
    next_cycle();
  endtask

  task automatic test_lat4();
    int en_cnt   = 0;
    int en_cyc   = -1;
    int done_cyc = -1;
    cpu_req4 = 1'b1; cpu_addr4 = 32'h20; mem_rdata4 = 32'hBAD0_0000;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (mem_en4) begin
        en_cnt++;
        if (en_cyc < 0) begin
          en_cyc = c;
          checks++;
          if ({mem_we4, mem_addr4, gnt4} !== {1'b0, 32'h20, 2'b01}) begin
            failures++;
            $display("FAIL lat4_issue: mem_we=%b mem_addr=%h gnt=%b required 0 00000020 01",
                     mem_we4, mem_addr4, gnt4);
          end
        end
      end
      if (cpu_done4 && done_cyc < 0) begin
        done_cyc = c;
        checks++;
        if (rdata4 !== 32'hCAFE_F00D) begin
          failures++;
          $display("FAIL lat4_rdata: rdata=%h required cafef00d", rdata4);
        end
      end
      if (c == 5) begin
        checks++;
        if (rdata4 !== 32'h0) begin
          failures++;
          $display("FAIL lat4_early: rdata=%h before capture, required 00000000", rdata4);
        end
      end
      next_cycle();
      mem_rdata4 = (c + 1 == 5) ? 32'hCAFE_F00D : 32'hBAD0_0000 + 32'(c + 1);
      if (c == 6) cpu_req4 = 1'b0;
    end
    checks++;
    if (en_cyc != 1 || en_cnt != 1) begin
      failures++;
      $display("FAIL lat4_strobe: first mem_en cycle=%0d count=%0d required 1 1", en_cyc, en_cnt);
    end
    checks++;
    if (done_cyc != 6) begin
      failures++;
      $display("FAIL lat4_done_cycle: cpu_done at cycle %0d required 6", done_cyc);
    end
    checks++;
    if (rdata4 !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL lat4_hold: rdata=%h after done, required cafef00d", rdata4);
    end
  endtask

  task automatic test_reset_wait();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt, mem_en, cpu_done} !== {2'b01, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rst_wait_pre: gnt=%b mem_en=%b cpu_done=%b required 01 0 0", gnt, mem_en, cpu_done);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt, mem_en, cpu_done, dma_done} !== '0 || cpu_stall !== 1'b1) begin
      failures++;
      $display("FAIL rst_wait_clear: gnt=%b mem_en=%b done=%b%b stall=%b required 00 0 00 1",
               gnt, mem_en, dma_done, cpu_done, cpu_stall);
    end
    next_cycle();
    rst = 1'b0;
    model_rdata = '0;
    sb.push_back('{1'b0, 32'hDEADBEEF});
    model_rdata = 32'hDEADBEEF;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (mem_en !== (c == 1) || cpu_done !== (c == 3)) begin
        failures++;
        $display("FAIL rst_wait_restart c=%0d: mem_en=%b cpu_done=%b required %b %b",
                 c, mem_en, cpu_done, (c == 1), (c == 3));
      end
      if (cpu_done || dma_done) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_rst_wait: done cpu=%b dma=%b with nothing expected", cpu_done, dma_done);
        end else begin
          e = sb.pop_front();
          if ({dma_done, cpu_done, rdata} !== {e.is_dma, ~e.is_dma, e.data}) begin
            failures++;
            $display("FAIL sb_rst_wait: dma=%b cpu=%b rdata=%h required dma=%b rdata=%h",
                     dma_done, cpu_done, rdata, e.is_dma, e.data);
          end
        end
      end
      next_cycle();
      if (c == 3) cpu_req = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int en_cyc [2];
    int dn_cyc [2];
    int n_en = 0;
    int n_dn = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h60; cpu_wdata = 32'h5555_5555;
    sb.push_back('{1'b0, model_rdata});
    sb.push_back('{1'b0, model_rdata});
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (mem_en === 1'b1) begin
        if (n_en < 2) en_cyc[n_en] = c;
        n_en++;
      end
      if (cpu_done || dma_done) begin
        if (n_dn < 2) dn_cyc[n_dn] = c;
        n_dn++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_b2b: done cpu=%b dma=%b with nothing expected", cpu_done, dma_done);
        end else begin
          e = sb.pop_front();
          if ({dma_done, cpu_done, rdata} !== {e.is_dma, ~e.is_dma, e.data}) begin
            failures++;
            $display("FAIL sb_b2b: dma=%b cpu=%b rdata=%h required dma=%b rdata=%h",
                     dma_done, cpu_done, rdata, e.is_dma, e.data);
          end
        end
      end
      if (c == 2 || c == 3) begin
        checks++;
        if (cpu_stall !== (c == 3)) begin
          failures++;
          $display("FAIL b2b_stall c=%0d: cpu_stall=%b required %b", c, cpu_stall, (c == 3));
        end
      end
      next_cycle();
      if (c == 5) cpu_req = 1'b0;
    end
    checks++;
    if (n_en != 2 || n_dn != 2) begin
      failures++;
      $display("FAIL b2b_count: mem_en pulses=%0d done pulses=%0d required 2 2", n_en, n_dn);
    end else begin
      checks++;
      if (en_cyc[0] != 1 || en_cyc[1] != 4 || dn_cyc[0] != 2 || dn_cyc[1] != 5) begin
        failures++;
        $display("FAIL b2b_spacing: mem_en at %0d,%0d done at %0d,%0d required 1,4 and 2,5",
                 en_cyc[0], en_cyc[1], dn_cyc[0], dn_cyc[1]);
      end
    end
  endtask

  task automatic test_drain();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d expected completions never seen", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_tie();
    test_lat4();
    test_reset_wait();
    test_back_to_back();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
